spi_draw_command_queue: RTL and testbench

- Sits directly downstream of spi_reader.
- Consumes its byte stream (byte_read, data, command, data_index) and assembles the 6 data bytes of each COMMAND_DRAW_SPRITE into one draw request.
- Buffers requests in a small FIFO.
- Presents them to the sprite renderer on a valid/ready interface.
- Decouples SPI arrival timing from renderer consumption.

---
 rtl/spi_draw_command_queue.sv | 177 +++++++++++++++++
 tb/tb_spi_draw_command_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_draw_command_queue.sv
// -----------------------------------------------------------------------------
// spi_draw_command_queue
//
// Watches the byte stream coming out of spi_reader and turns every complete
// DRAW_SPRITE command into one draw request. The six data bytes that follow
// the command byte are gathered into an assembly buffer. The finished request
// is pushed into a small FIFO. The sprite renderer drains the FIFO over a
// valid/ready handshake, so SPI arrival timing is decoupled from the renderer.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   cs                    SPI chip select (high = idle, aborts a partial request)
//   byte_read, data       new-byte pulse and byte value from spi_reader
//   command, data_index   spi_reader decode state, valid one cycle after byte_read
//   draw_valid/ready      handshake towards the renderer
//   sprite_id, pos_x,
//   pos_y, depth          fields of the head entry (zero while the FIFO is empty)
//   fill_level            number of stored entries, 0..DEPTH
//   overflow              sticky; a finished request was dropped on a full FIFO
// -----------------------------------------------------------------------------
module spi_draw_command_queue #(
    parameter int         DEPTH               = 8,
    parameter logic [7:0] COMMAND_DRAW_SPRITE = 8'h02
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cs,
    input  logic                       byte_read,
    input  logic [7:0]                 data,
    input  logic [7:0]                 command,
    input  logic [15:0]                data_index,
    output logic                       draw_valid,
    input  logic                       draw_ready,
    output logic [7:0]                 sprite_id,
    output logic [15:0]                pos_x,
    output logic [15:0]                pos_y,
    output logic [7:0]                 depth,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_COUNT = (PTR_W+1)'(DEPTH);
    localparam int               SLOTS       = 5;   // byte 6 goes straight into the push

    // ------------------------------------------------------------------
    // Input alignment: spi_reader updates command/data_index one cycle
    // after byte_read, so the byte itself is delayed by one register.
    // ------------------------------------------------------------------
    logic       byte_d_reg;
    logic [7:0] data_d_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_d_reg <= 1'b0;
            data_d_reg <= 8'h00;
        end else begin
            byte_d_reg <= byte_read;
            data_d_reg <= data;
        end
    end

    // ------------------------------------------------------------------
    // Assembly decode
    // ------------------------------------------------------------------
    logic assembling_reg;
    logic assembling_next;
    logic is_draw;
    logic start_req;
    logic store_byte;
    logic push_req;

    assign is_draw    = byte_d_reg && (command == COMMAND_DRAW_SPRITE);
    assign start_req  = is_draw && (data_index == 16'd0);
    assign store_byte = is_draw && assembling_reg &&
                        (data_index >= 16'd1) && (data_index <= 16'd5);
    assign push_req   = is_draw && assembling_reg && (data_index == 16'd6);

    always_comb begin
        assembling_next = assembling_reg;
        if (byte_d_reg) begin
            if (start_req)
                assembling_next = 1'b1;
            else if (push_req || !is_draw)
                assembling_next = 1'b0;
        end
        // Chip select going idle abandons whatever was half collected.
        if (cs)
            assembling_next = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset)
            assembling_reg <= 1'b0;
        else
            assembling_reg <= assembling_next;
    end

    // One register per buffered byte; slot gi takes data byte gi+1.
    logic [7:0] slot_reg [0:SLOTS-1];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (reset || start_req)
                    slot_reg[gi] <= 8'h00;
                else if (store_byte && (data_index == 16'(gi + 1)))
                    slot_reg[gi] <= data_d_reg;
            end
        end
    endgenerate

    // Entry layout, big-endian: id | x_hi | x_lo | y_hi | y_lo | depth.
    logic [47:0] push_entry;
    assign push_entry = {slot_reg[0], slot_reg[1], slot_reg[2],
                         slot_reg[3], slot_reg[4], data_d_reg};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [47:0]      mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             overflow_reg;
    logic             full;
    logic             pop;
    logic             push_accept;
    logic [47:0]      head;

    assign full        = (count_reg == DEPTH_COUNT);
    assign draw_valid  = (count_reg != '0);
    assign pop         = draw_valid && draw_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign push_accept = push_req && (!full || pop);

    always_comb begin
        count_next = count_reg;
        if (push_accept && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push_accept)
            count_next = count_reg - 1'b1;
    end

    // Storage carries no reset; the outputs are masked while empty instead.
    always_ff @(posedge clock) begin
        if (push_accept)
            mem[wr_ptr_reg] <= push_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push_accept)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_req && !push_accept)
                overflow_reg <= 1'b1;
        end
    end

    assign head       = draw_valid ? mem[rd_ptr_reg] : 48'h0;
    assign sprite_id  = head[47:40];
    assign pos_x      = head[39:24];
    assign pos_y      = head[23:8];
    assign depth      = head[7:0];
    assign fill_level = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_spi_draw_command_queue.sv
module tb_spi_draw_command_queue;

    localparam int         DEPTH = 8;
    localparam logic [7:0] CMD_DRAW = 8'h02;
    localparam logic [7:0] CMD_SAVE = 8'h03;

    logic        clock = 1'b0;
    logic        reset;
    logic        cs;
    logic        byte_read;
    logic [7:0]  data;
    logic [7:0]  command;
    logic [15:0] data_index;
    logic        draw_valid;
    logic        draw_ready;
    logic [7:0]  sprite_id;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [7:0]  depth;
    logic [3:0]  fill_level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    spi_draw_command_queue #(
        .DEPTH(DEPTH),
        .COMMAND_DRAW_SPRITE(CMD_DRAW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cs(cs),
        .byte_read(byte_read),
        .data(data),
        .command(command),
        .data_index(data_index),
        .draw_valid(draw_valid),
        .draw_ready(draw_ready),
        .sprite_id(sprite_id),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .depth(depth),
        .fill_level(fill_level),
        .overflow(overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a request is the 6 bytes following a DRAW command
    // byte within one chip-select session; it joins the queue on the edge
    // after the register stage, unless the queue is full with no pop.
    // ------------------------------------------------------------------
    logic [47:0] m_q[$];
    logic [7:0]  m_sess[$];
    logic        m_ovf = 1'b0;
    logic        m_pend = 1'b0;
    logic [47:0] m_pend_entry = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_sess.delete();
            m_ovf  = 1'b0;
            m_pend = 1'b0;
        end else begin
            if (m_q.size() != 0 && draw_ready)
                void'(m_q.pop_front());
            if (m_pend) begin
                if (m_q.size() < DEPTH)
                    m_q.push_back(m_pend_entry);
                else
                    m_ovf = 1'b1;
            end
            m_pend = 1'b0;
            if (cs) begin
                m_sess.delete();
            end else if (byte_read) begin
                m_sess.push_back(data);
                if (m_sess.size() == 7 && m_sess[0] == CMD_DRAW) begin
                    m_pend = 1'b1;
                    m_pend_entry = {m_sess[1], m_sess[2], m_sess[3],
                                    m_sess[4], m_sess[5], m_sess[6]};
                end
            end
        end
    end

    // Compare process: every cycle after the first edge.
    initial begin
        logic [47:0] exp;
        @(posedge clock);
        forever begin
            @(negedge clock);
            exp = (m_q.size() != 0) ? m_q[0] : 48'h0;
            check("model_valid", {63'h0, draw_valid}, {63'h0, m_q.size() != 0});
            check("model_fill", {60'h0, fill_level}, 64'(m_q.size()));
            check("model_overflow", {63'h0, overflow}, {63'h0, m_ovf});
            check("model_head", {16'h0, sprite_id, pos_x, pos_y, depth}, {16'h0, exp});
        end
    end

    // ------------------------------------------------------------------
    // spi_reader emulation
    // ------------------------------------------------------------------
    int sess_cnt = 0;

    task automatic start_session();
        @(negedge clock);
        cs = 1'b1;
        @(negedge clock);
        cs = 1'b0;
        sess_cnt = 0;
    endtask

    // Returns on the negedge right after the edge that sampled byte_read.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        byte_read = 1'b1;
        data      = b;
        @(negedge clock);
        byte_read = 1'b0;
        if (sess_cnt == 0)
            command = b;
        data_index = 16'(sess_cnt);
        sess_cnt++;
    endtask

    task automatic send_request(input logic [7:0] id, input logic [15:0] x,
                                input logic [15:0] y, input logic [7:0] d);
        $display("req id=%02h x=%04h y=%04h depth=%02h", id, x, y, d);
        start_session();
        send_byte(CMD_DRAW);
        send_byte(id);
        send_byte(x[15:8]);
        send_byte(x[7:0]);
        send_byte(y[15:8]);
        send_byte(y[7:0]);
        send_byte(d);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b1; byte_read = 1'b0; data = 8'h00;
        command = 8'h00; data_index = 16'h0; draw_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_valid", {63'h0, draw_valid}, 64'h0);
        check("reset_fill", {60'h0, fill_level}, 64'h0);
        check("reset_sprite", {56'h0, sprite_id}, 64'h0);
        reset = 1'b0;

        // Single request and latency.
        send_request(8'h03, 16'h0140, 16'h00F0, 8'h02);
        check("lat_one_edge_valid", {63'h0, draw_valid}, 64'h0);
        @(negedge clock);
        check("lat_two_edge_valid", {63'h0, draw_valid}, 64'h1);
        check("single_sprite", {56'h0, sprite_id}, 64'h03);
        check("single_x", {48'h0, pos_x}, 64'h0140);
        check("single_y", {48'h0, pos_y}, 64'h00F0);
        check("single_depth", {56'h0, depth}, 64'h02);
        check("single_fill", {60'h0, fill_level}, 64'h1);
        draw_ready = 1'b1;
        @(negedge clock);
        draw_ready = 1'b0;
        check("single_drained", {60'h0, fill_level}, 64'h0);

        // Back-pressure: nine requests into eight slots.
        for (int i = 1; i <= 9; i++)
            send_request(8'(i), 16'(i * 16'h0101), 16'(i * 3), 8'(i));
        @(negedge clock);
        check("bp_fill", {60'h0, fill_level}, 64'h8);
        check("bp_overflow", {63'h0, overflow}, 64'h1);
        draw_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("bp_order", {56'h0, sprite_id}, 64'(i));
            @(negedge clock);
        end
        draw_ready = 1'b0;
        check("bp_empty", {63'h0, draw_valid}, 64'h0);

        // Full plus simultaneous pop in the commit cycle.
        pulse_reset();
        check("ovf_cleared", {63'h0, overflow}, 64'h0);
        for (int i = 0; i < 8; i++)
            send_request(8'(8'h10 + i), 16'h0010, 16'h0020, 8'h01);
        send_request(8'h20, 16'h1234, 16'h5678, 8'h09);
        draw_ready = 1'b1;
        @(negedge clock);
        draw_ready = 1'b0;
        check("simul_fill", {60'h0, fill_level}, 64'h8);
        check("simul_overflow", {63'h0, overflow}, 64'h0);
        check("simul_head", {56'h0, sprite_id}, 64'h11);
        draw_ready = 1'b1;
        repeat (8) @(negedge clock);
        draw_ready = 1'b0;
        check("simul_empty", {63'h0, draw_valid}, 64'h0);

        // Abort a partial request with chip select.
        start_session();
        send_byte(CMD_DRAW);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_request(8'h07, 16'h0102, 16'h0304, 8'h05);
        @(negedge clock);
        check("abort_fill", {60'h0, fill_level}, 64'h1);
        check("abort_entry", {16'h0, sprite_id, pos_x, pos_y, depth}, 64'h0007_0102_0304_05);
        draw_ready = 1'b1;
        @(negedge clock);
        draw_ready = 1'b0;

        // Foreign command whose payload looks like draw traffic.
        $display("req foreign SAVE_SPRITE 513 bytes");
        start_session();
        send_byte(CMD_SAVE);
        for (int i = 1; i <= 512; i++)
            send_byte((i % 7 == 0) ? CMD_DRAW : 8'(i));
        repeat (2) @(negedge clock);
        check("foreign_fill", {60'h0, fill_level}, 64'h0);

        // Reset with entries queued and a request half assembled.
        for (int i = 0; i < 3; i++)
            send_request(8'(8'h30 + i), 16'h0001, 16'h0002, 8'h03);
        start_session();
        send_byte(CMD_DRAW);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        check("pre_reset_fill", {60'h0, fill_level}, 64'h3);
        pulse_reset();
        check("rst_valid", {63'h0, draw_valid}, 64'h0);
        check("rst_fill", {60'h0, fill_level}, 64'h0);
        check("rst_overflow", {63'h0, overflow}, 64'h0);
        send_request(8'h09, 16'h00AB, 16'h00CD, 8'h0E);
        @(negedge clock);
        check("post_rst_fill", {60'h0, fill_level}, 64'h1);
        check("post_rst_entry", {16'h0, sprite_id, pos_x, pos_y, depth}, 64'h0009_00AB_00CD_0E);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
